instr_fetch_unit: RTL

Fetch stage of the multi-cycle RISC-V core. Owns the program counter, fetches one 32-bit instruction per request from instruction memory over a req/ready handshake, and latches it into the instruction register alongside the PC it came from (oldpc). Its `instr` output feeds the decoder and the immediate extender (`instr[31:7]`); `oldpc` feeds the branch/jump target adder. It sits directly upstream of decode/extend, under control of the main controller FSM.

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the multi-cycle RISC-V core.
// Owns the PC, issues one instruction fetch per request over a req/ready
// handshake, and holds the fetched word plus the PC it came from until the
// next successful fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fetch_start,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] oldpc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned CNT_W     = 8;  // WAIT_MAX-1 is at most 255

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      oldpc_q, oldpc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;

  logic misaligned;
  logic timeout;
  logic leave_req;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign timeout    = (cnt_q == CNT_W'(WAIT_MAX - 1));
  assign leave_req  = (state_q == S_REQ) && (mem_ready || timeout);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (fetch_start) state_d = misaligned ? S_FAULT : S_REQ;
      S_REQ: begin
        if (mem_ready)    state_d = S_DONE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so no input-to-output combinational path
  always_comb begin
    mem_req     = 1'b0;
    busy        = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    unique case (state_q)
      S_REQ: begin
        mem_req = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:  instr_valid = 1'b1;
      S_FAULT: fault       = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: PC, pending PC, wait counter, instruction register, cause
  always_comb begin
    pc_d     = pc_q;
    oldpc_d  = oldpc_q;
    instr_d  = instr_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          cause_d = misaligned ? 2'b01 : 2'b00;
          cnt_d   = '0;
        end
        if (pc_we) pc_d = pc_next;
      end
      S_REQ: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          oldpc_d = pc_q;
        end else if (timeout) begin
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // PC writes during a request are deferred so mem_addr stays stable;
        // a write on the exit edge itself is the newest and wins.
        if (leave_req) begin
          pend_v_d = 1'b0;
          if (pc_we)         pc_d = pc_next;
          else if (pend_v_q) pc_d = pend_q;
        end else if (pc_we) begin
          pend_d   = pc_next;
          pend_v_d = 1'b1;
        end
      end
      default: begin
        if (pc_we) pc_d = pc_next;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      instr_q  <= NOP_INSTR;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      cnt_q    <= '0;
      cause_q  <= 2'b00;
    end else begin
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      instr_q  <= instr_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
    end
  end

  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign oldpc       = oldpc_q;
  assign instr       = instr_q;
  assign fault_cause = cause_q;

endmodule
